// File: rtl/seq_101_pattern_gen.sv
// Serial pattern generator: shifts a captured word out MSB first, rpt+1 times,
// while counting non-overlapping "101" occurrences in the emitted bit stream.
//
// state | meaning
// IDLE  | waiting for start; outputs low, exp_count holds last value
// SHIFT | emitting one pattern bit per clock
// DONE  | one-cycle completion pulse after the final bit
module seq_101_pattern_gen #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] data,
  input  logic [3:0]       rpt,
  output logic             busy,
  output logic             out,
  output logic             out_valid,
  output logic             done,
  output logic [CNT_W-1:0] exp_count
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BW-1:0] LAST_IDX = BW'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2
  } trk_t;

  state_t           state, state_nxt;
  trk_t             trk, trk_nxt;
  logic [WIDTH-1:0] word_q;
  logic [3:0]       pass_cnt;
  logic [BW-1:0]    bit_cnt;
  logic             cur_bit;
  logic             match;
  logic             last_bit;

  assign cur_bit  = word_q[bit_cnt];
  assign last_bit = (bit_cnt == '0) && (pass_cnt == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (last_bit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = 1'b0;
    out_valid = 1'b0;
    out       = 1'b0;
    done      = 1'b0;
    case (state)
      SHIFT: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out       = cur_bit;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Tracker restarts from T0 after a match, so matches never overlap.
  always_comb begin
    trk_nxt = trk;
    match   = 1'b0;
    case (trk)
      T0: trk_nxt = cur_bit ? T1 : T0;
      T1: trk_nxt = cur_bit ? T1 : T2;
      T2: begin
        trk_nxt = T0;
        match   = cur_bit;
      end
      default: trk_nxt = T0;
    endcase
  end

  // bit_cnt and pass_cnt are down-counters; last_bit is their joint terminal count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_q    <= '0;
      pass_cnt  <= '0;
      bit_cnt   <= '0;
      trk       <= T0;
      exp_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            word_q    <= data;
            pass_cnt  <= rpt;
            bit_cnt   <= LAST_IDX;
            trk       <= T0;
            exp_count <= '0;
          end
        end
        SHIFT: begin
          if (bit_cnt == '0) begin
            bit_cnt <= LAST_IDX;
            if (pass_cnt != '0) pass_cnt <= pass_cnt - 4'd1;
          end else begin
            bit_cnt <= bit_cnt - BW'(1);
          end
          trk <= trk_nxt;
          if (match && (exp_count != CNT_MAX)) exp_count <= exp_count + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
